// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and types for the nibble-serial adder controller.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Bus between the serial controller (master) and the external 4-bit ripple-carry adder (slave).
interface nibble_serial_adder_if;
  import nibble_adder_pkg::*;

  logic [NIBBLE_W-1:0] add_a;
  logic [NIBBLE_W-1:0] add_b;
  logic                add_cin;
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;

  modport master (output add_a, add_b, add_cin, input add_sum, add_cout);
  modport slave  (input add_a, add_b, add_cin, output add_sum, add_cout);

endinterface

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per clock through an external 4-bit adder.
// Optional signed-overflow flag output is enabled by defining OVERFLOW_DETECT_EN.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 cin_i,
  nibble_serial_adder_if.master adder,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIDTH-1:0]     sum_o,
  output logic                 cout_o
`ifdef OVERFLOW_DETECT_EN
  ,
  output logic                 ovf_o
`endif
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : gWidthCheck
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  nsa_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef OVERFLOW_DETECT_EN
  logic             ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef OVERFLOW_DETECT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // The adder bus is only driven in RUN so the external adder sees zeros while idle.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    carry_d       = carry_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    cout_d        = cout_q;
`ifdef OVERFLOW_DETECT_EN
    ovf_d         = ovf_q;
`endif
    adder.add_a   = '0;
    adder.add_b   = '0;
    adder.add_cin = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        adder.add_a   = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
        adder.add_b   = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
        adder.add_cin = carry_q;
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = adder.add_sum;
        carry_d = adder.add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
          cout_d  = adder.add_cout;
`ifdef OVERFLOW_DETECT_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (adder.add_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef OVERFLOW_DETECT_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: 4-bit adder model on the bus, scoreboard of expected results per start.
module tb_nibble_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } expT;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        carryIn;
  logic        busy;
  logic        done;
  logic [15:0] sumOut;
  logic        coutOut;
`ifdef OVERFLOW_DETECT_EN
  logic        ovfOut;
`endif

  expT sbQueue[$];
  int  checkCount = 0;
  int  failCount  = 0;
  int  doneCount  = 0;
  int  cycleNum   = 0;
  int  lastDoneCycle = 0;

  nibble_serial_adder_if adderBus();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .a_i     (opA),
    .b_i     (opB),
    .cin_i   (carryIn),
    .adder   (adderBus),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sumOut),
    .cout_o  (coutOut)
`ifdef OVERFLOW_DETECT_EN
    ,
    .ovf_o   (ovfOut)
`endif
  );

  assign {adderBus.add_cout, adderBus.add_sum} =
    {1'b0, adderBus.add_a} + {1'b0, adderBus.add_b} + {4'b0, adderBus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNum++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic [15:0] aVal, input logic [15:0] bVal, input logic cVal);
    expT         e;
    logic [16:0] full;
    full   = {1'b0, aVal} + {1'b0, bVal} + {16'b0, cVal};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (aVal[15] == bVal[15]) && (full[15] != aVal[15]);
    sbQueue.push_back(e);
  endtask

  // Called at posedge+2 with the DUT in IDLE; returns at posedge+2 after the accepting edge.
  task automatic applyStimulus(input logic [15:0] aVal, input logic [15:0] bVal, input logic cVal);
    start   = 1'b1;
    opA     = aVal;
    opB     = bVal;
    carryIn = cVal;
    @(posedge clk);
    pushExpected(aVal, bVal, cVal);
    #2;
    start   = 1'b0;
    opA     = 16'($urandom);
    opB     = 16'($urandom);
    carryIn = 1'($urandom);
  endtask

  task automatic waitDone(output int doneCycle, output int busyCycles);
    doneCycle  = 0;
    busyCycles = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (done) begin
        doneCycle = k;
        break;
      end
    end
  endtask

  task automatic runOp(input logic [15:0] aVal, input logic [15:0] bVal, input logic cVal);
    int dc, bc;
    applyStimulus(aVal, bVal, cVal);
    waitDone(dc, bc);
    checkOutput("doneLatency", dc, 5);
    checkOutput("busyCycles", bc, 4);
    @(posedge clk);
    #2;
    checkOutput("idleDone", done, 0);
    checkOutput("idleBusy", busy, 0);
    checkOutput("idleAdderBus", {adderBus.add_a, adderBus.add_b, adderBus.add_cin}, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      expT e;
      doneCount++;
      lastDoneCycle = cycleNum;
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("sum", sumOut, e.sum);
        checkOutput("cout", coutOut, e.cout);
`ifdef OVERFLOW_DETECT_EN
        checkOutput("ovf", ovfOut, e.ovf);
`endif
      end
    end
  end

  initial begin
    int doneBefore;
    int firstDone;
    rst_n   = 1'b0;
    start   = 1'b0;
    opA     = '0;
    opB     = '0;
    carryIn = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetSum", sumOut, 0);
    checkOutput("resetCout", coutOut, 0);
    checkOutput("resetAdderBus", {adderBus.add_a, adderBus.add_b, adderBus.add_cin}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    runOp(16'hFFFF, 16'h0001, 1'b0);
    runOp(16'h1234, 16'h4321, 1'b1);
    runOp(16'h7FFF, 16'h0001, 1'b0);

    // Start held through RUN and DONE with shifting operands must not retrigger.
    doneBefore = doneCount;
    start   = 1'b1;
    opA     = 16'h0102;
    opB     = 16'h0304;
    carryIn = 1'b0;
    @(posedge clk);
    pushExpected(16'h0102, 16'h0304, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #2;
      opA     = 16'($urandom);
      opB     = 16'($urandom);
      carryIn = 1'($urandom);
      @(posedge clk);
    end
    #2;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    checkOutput("ignoreDoneCount", doneCount - doneBefore, 1);
    checkOutput("ignoreSumHeld", sumOut, 16'h0406);

    // Async reset while idx == 2.
    applyStimulus(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("preResetBusy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetDone", done, 0);
    checkOutput("midResetSum", sumOut, 0);
    checkOutput("midResetCout", coutOut, 0);
    sbQueue.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    runOp(16'h0F0F, 16'h00F1, 1'b0);

    // Back-to-back: restart in the IDLE cycle right after done.
    runOp(16'h1111, 16'h2222, 1'b0);
    firstDone = lastDoneCycle;
    checkOutput("b2bSumHeld", sumOut, 16'h3333);
    runOp(16'h8000, 16'h8000, 1'b1);
    checkOutput("b2bGap", lastDoneCycle - firstDone, 6);

    for (int k = 0; k < 3; k++) begin
      runOp(16'($urandom), 16'($urandom), 1'($urandom));
    end

    checkOutput("scoreboardEmpty", sbQueue.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
